imem_loader: RTL and testbench

- Writer side of the instruction-memory interface that the processor core only ever reads.
- Accepts a byte stream over a valid/ready handshake and packs bytes big-endian into 32-bit words.
- Writes the words into instruction memory at consecutive word-aligned addresses.
- Holds the core in reset until the program image is fully loaded.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_byte_packer.sv | 57 +++++
 rtl/imem_loader.sv | 155 +++++++++++++++
 tb/tb_imem_loader.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_e    : FSM encodings (Idle=0, Recv=1, Write=2, Chk=3, Done=4)
//   WordBytes  : bytes per instruction word
//   AddrStride : byte-address increment between consecutive words
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRecv  = 3'd1,
    StWrite = 3'd2,
    StChk   = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam int unsigned WordBytes  = 4;
  localparam logic [31:0] AddrStride = 32'h4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream big-endian into 32-bit words.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : restart packing at byte index 0
//   byte_en_i     : a byte is accepted this cycle
//   byte_i        : accepted byte
//   data_o        : word under assembly (holds value between accepts)
//   word_full_o   : combinational pulse on acceptance of the last byte of a word
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] data_o,
  output logic        word_full_o
);

  localparam logic [1:0] LastIdx = 2'(WordBytes - 1);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    idx_d       = idx_q;
    data_d      = data_q;
    word_full_o = 1'b0;
    if (clear_i) begin
      idx_d = '0;
    end else if (byte_en_i) begin
      unique case (idx_q)
        2'd0: data_d[31:24] = byte_i;
        2'd1: data_d[23:16] = byte_i;
        2'd2: data_d[15:8]  = byte_i;
        2'd3: data_d[7:0]   = byte_i;
        default: ;
      endcase
      // Index wraps 3 -> 0 naturally in two bits.
      idx_d       = idx_q + 2'd1;
      word_full_o = (idx_q == LastIdx);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream, packs it into words and
// writes them to consecutive word addresses from BASE_ADDR, holding the core in
// reset until the image is loaded.
//   clk_i, rst_ni        : clock, async active-low reset
//   start_i              : load request (honoured only in Idle/Done)
//   word_count_i         : words to load, captured with start
//   byte_i/byte_valid_i  : stream input; byte_ready_o is the handshake back
//   wr_en_o/wr_addr_o/wr_data_o : memory write port, one strobe per word
//   cpu_hold_o           : keep the core in reset
//   busy_o, done_o       : load status
//   error_o              : checksum mismatch (0 unless checksum build)
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] word_count_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic             wr_en_o,
  output logic [31:0]      wr_addr_o,
  output logic [31:0]      wr_data_o,
  output logic             cpu_hold_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e StFinal = StChk;
`else
  localparam state_e StFinal = StDone;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] idx_inc;
  logic [31:0]      addr_q, addr_d;
  logic             start_acc;
  logic             recv_acc;
  logic             word_full;

  assign start_acc = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign recv_acc  = byte_valid_i && (state_q == StRecv);
  assign idx_inc   = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};

  imem_loader_byte_packer u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (start_acc),
    .byte_en_i   (recv_acc),
    .byte_i      (byte_i),
    .data_o      (wr_data_o),
    .word_full_o (word_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic       err_q, err_d;
  logic [7:0] xor_q, xor_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    err_d   = err_q;
    xor_d   = xor_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start_acc) begin
          count_d = word_count_i;
          idx_d   = '0;
          addr_d  = BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
          err_d   = 1'b0;
          xor_d   = 8'h00;
`endif
          state_d = (word_count_i == '0) ? StFinal : StRecv;
        end
      end
      StRecv: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (recv_acc) xor_d = xor_q ^ byte_i;
`endif
        if (word_full) state_d = StWrite;
      end
      StWrite: begin
        // addr_q always tracks BASE_ADDR + 4*idx_q; advance both together.
        idx_d   = idx_inc;
        addr_d  = addr_q + AddrStride;
        state_d = (idx_inc == count_q) ? StFinal : StRecv;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        if (byte_valid_i) begin
          err_d   = (byte_i != xor_q);
          state_d = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
      xor_q <= 8'h00;
    end else begin
      err_q <= err_d;
      xor_q <= xor_d;
    end
  end

  assign byte_ready_o = (state_q == StRecv) || (state_q == StChk);
  assign error_o      = err_q;
  // A failed checksum keeps the core held even though the load is done.
  assign cpu_hold_o   = (state_q != StDone) || err_q;
`else
  assign byte_ready_o = (state_q == StRecv);
  assign error_o      = 1'b0;
  assign cpu_hold_o   = (state_q != StDone);
`endif

  assign wr_en_o   = (state_q == StWrite);
  assign wr_addr_o = addr_q;
  assign busy_o    = (state_q == StRecv) || (state_q == StWrite) || (state_q == StChk);
  assign done_o    = (state_q == StDone);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;
  logic [7:0]  tb_xor;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .word_count_i (word_count),
    .byte_i       (byte_in),
    .byte_valid_i (byte_valid),
    .byte_ready_o (byte_ready),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .cpu_hold_o   (cpu_hold),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error)
  );

  // Record every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; word_count = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    log_addr.delete(); log_data.delete();
  endtask

  task automatic do_start(input logic [9:0] n);
    start = 1'b1; word_count = n; tb_xor = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; returns #1 after the accepting edge.
  task automatic push_byte(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_in = b; byte_valid = 1'b1;
    @(negedge clk);
    while (byte_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      $display("FAIL byte_handshake: byte_ready=%b after %0d cycles, required 1", byte_ready, n);
      failures++;
      checks++;
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    tb_xor = tb_xor ^ b;
  endtask

  task automatic push_word(input logic [31:0] w, input int gap);
    push_byte(w[31:24], gap);
    push_byte(w[23:16], gap);
    push_byte(w[15:8], gap);
    push_byte(w[7:0], gap);
  endtask

  // Trailing checksum byte (only exists in the checksum build).
  task automatic push_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_byte(tb_xor, 0);
`endif
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0; #1;
    if (byte_ready !== 1'b0) begin $display("FAIL rst_byte_ready: got %b need 0", byte_ready); failures++; end
    checks++;
    if (wr_en !== 1'b0) begin $display("FAIL rst_wr_en: got %b need 0", wr_en); failures++; end
    checks++;
    if (wr_addr !== 32'h0) begin $display("FAIL rst_wr_addr: got %h need 0", wr_addr); failures++; end
    checks++;
    if (wr_data !== 32'h0) begin $display("FAIL rst_wr_data: got %h need 0", wr_data); failures++; end
    checks++;
    if ({busy, done, error, cpu_hold} !== 4'b0001) begin
      $display("FAIL rst_status: busy/done/error/hold got %b need 0001", {busy, done, error, cpu_hold});
      failures++;
    end
    checks++;
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    do_start(10'd2);
    if ({busy, cpu_hold, byte_ready} !== 3'b111) begin
      $display("FAIL basic_recv: busy/hold/ready got %b need 111", {busy, cpu_hold, byte_ready});
      failures++;
    end
    checks++;
    push_word(32'h2008_0005, 0);
    push_word(32'h0000_0000, 0);
    // Now in the second write cycle.
    if ({wr_en, byte_ready} !== 2'b10) begin
      $display("FAIL basic_write2: wr_en/ready got %b need 10", {wr_en, byte_ready});
      failures++;
    end
    checks++;
    if (wr_addr !== 32'h4) begin $display("FAIL basic_addr2: got %h need 4", wr_addr); failures++; end
    checks++;
`ifndef IMEM_LOADER_CHECKSUM_EN
    @(posedge clk); #1;
    if ({done, cpu_hold, busy} !== 3'b100) begin
      $display("FAIL basic_done_next: done/hold/busy got %b need 100", {done, cpu_hold, busy});
      failures++;
    end
    checks++;
`endif
    push_trailer();
    @(posedge clk); #1;
    if ({done, cpu_hold, error} !== 3'b100) begin
      $display("FAIL basic_done: done/hold/error got %b need 100", {done, cpu_hold, error});
      failures++;
    end
    checks++;
    if (log_addr.size() != 2) begin
      $display("FAIL basic_nwrites: got %0d need 2", log_addr.size()); failures++;
    end else begin
      if (log_addr[0] !== 32'h0 || log_data[0] !== 32'h2008_0005) begin
        $display("FAIL basic_w0: got %h/%h need 0/20080005", log_addr[0], log_data[0]); failures++;
      end
      checks++;
      if (log_addr[1] !== 32'h4 || log_data[1] !== 32'h0) begin
        $display("FAIL basic_w1: got %h/%h need 4/0", log_addr[1], log_data[1]); failures++;
      end
    end
    checks++;
  endtask

  task automatic test_stall();
    int gaps [8] = '{0, 2, 0, 1, 3, 0, 2, 1};
    logic [7:0] img [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    do_start(10'd2);
    for (int i = 0; i < 8; i++) push_byte(img[i], gaps[i]);
    push_trailer();
    repeat (3) @(posedge clk); #1;
    if (done !== 1'b1) begin $display("FAIL stall_done: got %b need 1", done); failures++; end
    checks++;
    if (log_addr.size() != 2) begin
      $display("FAIL stall_nwrites: got %0d need 2", log_addr.size()); failures++;
    end else if (log_addr[0] !== 32'h0 || log_data[0] !== 32'h2008_0005 ||
                 log_addr[1] !== 32'h4 || log_data[1] !== 32'h0) begin
      $display("FAIL stall_writes: got %h/%h %h/%h need 0/20080005 4/0",
               log_addr[0], log_data[0], log_addr[1], log_data[1]);
      failures++;
    end
    checks++;
  endtask

  task automatic test_zero();
    do_reset();
    do_start(10'd0);
    push_trailer();
    if ({done, cpu_hold, busy} !== 3'b100) begin
      $display("FAIL zero_done: done/hold/busy got %b need 100", {done, cpu_hold, busy});
      failures++;
    end
    checks++;
    repeat (2) @(posedge clk); #1;
    if (log_addr.size() != 0) begin
      $display("FAIL zero_nwrites: got %0d need 0", log_addr.size()); failures++;
    end
    checks++;
  endtask

  task automatic test_abort();
    do_reset();
    do_start(10'd3);
    push_word(32'h0102_0304, 0);
    push_byte(8'h55, 0);
    push_byte(8'h66, 0);
    #2 rst_n = 1'b0;
    #1;
    if ({busy, done, cpu_hold, byte_ready, wr_en} !== 5'b00100) begin
      $display("FAIL abort_status: busy/done/hold/ready/wr_en got %b need 00100",
               {busy, done, cpu_hold, byte_ready, wr_en});
      failures++;
    end
    checks++;
    if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      $display("FAIL abort_outputs: addr/data got %h/%h need 0/0", wr_addr, wr_data); failures++;
    end
    checks++;
    repeat (3) @(posedge clk); #1;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h0 || log_data[0] !== 32'h0102_0304) begin
      $display("FAIL abort_partial: nwrites %0d need 1 (word 0 at 0)", log_addr.size());
      failures++;
    end
    checks++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    log_addr.delete(); log_data.delete();
    do_start(10'd1);
    push_word(32'h1122_3344, 1);
    push_trailer();
    @(posedge clk); #1;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h0 || log_data[0] !== 32'h1122_3344) begin
      $display("FAIL abort_reload: nwrites %0d need 1 at 0 with 11223344", log_addr.size());
      failures++;
    end
    checks++;
  endtask

  task automatic test_start_ignored();
    do_reset();
    do_start(10'd2);
    push_byte(8'hDE, 0);
    push_byte(8'hAD, 0);
    start = 1'b1; word_count = 10'd1;
    @(posedge clk); #1;
    start = 1'b0;
    if ({busy, byte_ready, wr_addr} !== {2'b11, 32'h0}) begin
      $display("FAIL ign_state: busy/ready/addr got %b%b/%h need 11/0", busy, byte_ready, wr_addr);
      failures++;
    end
    checks++;
    push_byte(8'hBE, 0);
    push_byte(8'hEF, 0);
    push_word(32'h0102_0304, 0);
    push_trailer();
    @(posedge clk); #1;
    if (done !== 1'b1) begin $display("FAIL ign_done: got %b need 1", done); failures++; end
    checks++;
    if (log_addr.size() != 2 || log_data[0] !== 32'hDEAD_BEEF ||
        log_addr[1] !== 32'h4 || log_data[1] !== 32'h0102_0304) begin
      $display("FAIL ign_writes: nwrites %0d need 2 (DEADBEEF@0, 01020304@4)", log_addr.size());
      failures++;
    end
    checks++;
    log_addr.delete(); log_data.delete();
    do_start(10'd1);
    if ({done, busy, cpu_hold} !== 3'b011 || wr_addr !== 32'h0) begin
      $display("FAIL restart: done/busy/hold got %b addr %h need 011 addr 0",
               {done, busy, cpu_hold}, wr_addr);
      failures++;
    end
    checks++;
    push_word(32'hCAFE_F00D, 0);
    push_trailer();
    @(posedge clk); #1;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h0 || log_data[0] !== 32'hCAFE_F00D ||
        done !== 1'b1) begin
      $display("FAIL restart_load: nwrites %0d done %b need 1 write CAFEF00D@0, done 1",
               log_addr.size(), done);
      failures++;
    end
    checks++;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    do_start(10'd1);
    push_word(32'hAABB_CCDD, 0);
    push_byte(8'h00, 0);
    if ({done, error, cpu_hold} !== 3'b100) begin
      $display("FAIL cks_good: done/error/hold got %b need 100", {done, error, cpu_hold});
      failures++;
    end
    checks++;
    do_start(10'd1);
    if (error !== 1'b0) begin $display("FAIL cks_clear: got %b need 0", error); failures++; end
    checks++;
    push_word(32'hAABB_CCDD, 0);
    push_byte(8'h01, 0);
    if ({done, error, cpu_hold} !== 3'b111) begin
      $display("FAIL cks_bad: done/error/hold got %b need 111", {done, error, cpu_hold});
      failures++;
    end
    checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_abort();
    test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
